// File: rtl/x_commit_tracker.sv
`default_nettype none
// ============================================================================
// Module   : x_commit_tracker
// Brief    : CV-X-IF in-flight tracker. Holds execution-unit completions until
//            the core commits the ID, drops killed results, and drives the
//            result interface through a one-entry registered output stage.
//            Optional early-abort notification: X_COMMIT_TRACKER_KILL_NOTIFY_EN.
// Revision : 1.0
// ============================================================================
module x_commit_tracker #(
  parameter int ID_WIDTH     = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [ID_WIDTH-1:0]   issue_id_i,
  input  logic                  issue_accept_i,
  input  logic                  commit_valid_i,
  input  logic [ID_WIDTH-1:0]   commit_id_i,
  input  logic                  commit_kill_i,
  input  logic                  exec_valid_i,
  output logic                  exec_ready_o,
  input  logic [ID_WIDTH-1:0]   exec_id_i,
  input  logic [DATA_WIDTH-1:0] exec_data_i,
  input  logic                  exec_we_i,
  input  logic [4:0]            exec_rd_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [ID_WIDTH-1:0]   result_id_o,
  output logic [DATA_WIDTH-1:0] result_data_o,
  output logic                  result_we_o,
  output logic [4:0]            result_rd_o,
  output logic [ID_WIDTH:0]     inflight_cnt_o,
  output logic                  protocol_err_o
`ifdef X_COMMIT_TRACKER_KILL_NOTIFY_EN
  ,
  output logic                  kill_valid_o,
  output logic [ID_WIDTH-1:0]   kill_id_o
`endif
);

  localparam int                c_num_entries  = 2**ID_WIDTH;
  localparam logic [ID_WIDTH:0] c_max_inflight = (ID_WIDTH+1)'(MAX_INFLIGHT);
  localparam logic [ID_WIDTH:0] c_cnt_one      = {{ID_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_ISSUED    = 2'd1,
    ST_COMMITTED = 2'd2,
    ST_KILLED    = 2'd3
  } entry_state_e;

  entry_state_e r_state     [c_num_entries];
  entry_state_e w_state_nxt [c_num_entries];

  logic [ID_WIDTH:0]     r_cnt;
  logic [ID_WIDTH:0]     w_cnt_nxt;
  logic                  r_err;
  logic                  r_res_valid;
  logic [ID_WIDTH-1:0]   r_res_id;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_we;
  logic [4:0]            r_res_rd;

  entry_state_e w_issue_st;
  entry_state_e w_commit_st;
  entry_state_e w_exec_st;
  logic         w_issue_ready;
  logic         w_exec_ready;
  logic         w_alloc;
  logic         w_commit_ok;
  logic         w_commit_err;
  logic         w_exec_fire;
  logic         w_exec_free;
  logic         w_exec_load;
  logic         w_exec_err;

  // All decisions below use pre-edge entry state, so a completion racing a
  // commit of the same ID stalls, and a freeing ID cannot be re-issued yet.
  assign w_issue_st  = r_state[issue_id_i];
  assign w_commit_st = r_state[commit_id_i];
  assign w_exec_st   = r_state[exec_id_i];

  assign w_issue_ready = (w_issue_st == ST_FREE) && (r_cnt < c_max_inflight);
  assign w_alloc       = issue_valid_i && w_issue_ready && issue_accept_i;

  assign w_commit_ok  = commit_valid_i && (w_commit_st == ST_ISSUED);
  assign w_commit_err = commit_valid_i && (w_commit_st != ST_ISSUED);

  always_comb begin
    w_exec_ready = 1'b1;
    case (w_exec_st)
      ST_ISSUED:    w_exec_ready = 1'b0;
      ST_COMMITTED: w_exec_ready = !r_res_valid || result_ready_i;
      default:      w_exec_ready = 1'b1;
    endcase
  end

  assign w_exec_fire = exec_valid_i && w_exec_ready;
  assign w_exec_load = w_exec_fire && (w_exec_st == ST_COMMITTED);
  assign w_exec_free = w_exec_fire && ((w_exec_st == ST_COMMITTED) || (w_exec_st == ST_KILLED));
  assign w_exec_err  = w_exec_fire && (w_exec_st == ST_FREE);

  // Allocation needs FREE, commit needs ISSUED, release needs COMMITTED or
  // KILLED, so at most one of the three can target a given entry per cycle.
  always_comb begin
    for (int i = 0; i < c_num_entries; i++) begin
      w_state_nxt[i] = r_state[i];
      if (w_alloc && (issue_id_i == ID_WIDTH'(i))) begin
        w_state_nxt[i] = ST_ISSUED;
      end
      if (w_commit_ok && (commit_id_i == ID_WIDTH'(i))) begin
        w_state_nxt[i] = commit_kill_i ? ST_KILLED : ST_COMMITTED;
      end
      if (w_exec_free && (exec_id_i == ID_WIDTH'(i))) begin
        w_state_nxt[i] = ST_FREE;
      end
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_alloc && !w_exec_free) begin
      w_cnt_nxt = r_cnt + c_cnt_one;
    end else if (!w_alloc && w_exec_free) begin
      w_cnt_nxt = r_cnt - c_cnt_one;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < c_num_entries; i++) begin
        r_state[i] <= ST_FREE;
      end
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < c_num_entries; i++) begin
        r_state[i] <= w_state_nxt[i];
      end
      r_cnt <= w_cnt_nxt;
      if (w_commit_err || w_exec_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // Output stage: a load may coincide with a drain, giving one result per cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
      r_res_we    <= 1'b0;
      r_res_rd    <= '0;
    end else if (w_exec_load) begin
      r_res_valid <= 1'b1;
      r_res_id    <= exec_id_i;
      r_res_data  <= exec_data_i;
      r_res_we    <= exec_we_i;
      r_res_rd    <= exec_rd_i;
    end else if (result_ready_i) begin
      r_res_valid <= 1'b0;
    end
  end

`ifdef X_COMMIT_TRACKER_KILL_NOTIFY_EN
  logic                r_kill_valid;
  logic [ID_WIDTH-1:0] r_kill_id;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_kill_valid <= 1'b0;
      r_kill_id    <= '0;
    end else begin
      r_kill_valid <= w_commit_ok && commit_kill_i;
      if (w_commit_ok && commit_kill_i) begin
        r_kill_id <= commit_id_i;
      end
    end
  end

  assign kill_valid_o = r_kill_valid;
  assign kill_id_o    = r_kill_id;
`endif

  assign issue_ready_o  = w_issue_ready;
  assign exec_ready_o   = w_exec_ready;
  assign result_valid_o = r_res_valid;
  assign result_id_o    = r_res_id;
  assign result_data_o  = r_res_data;
  assign result_we_o    = r_res_we;
  assign result_rd_o    = r_res_rd;
  assign inflight_cnt_o = r_cnt;
  assign protocol_err_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_x_commit_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_commit_tracker
// Brief    : Directed stimulus for x_commit_tracker with a per-cycle model check.
// Revision : 1.0
// ============================================================================
module tb_x_commit_tracker;

  localparam int ID_WIDTH     = 4;
  localparam int MAX_INFLIGHT = 4;
  localparam int DATA_WIDTH   = 32;
  localparam int NUM_IDS      = 2**ID_WIDTH;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  issue_valid_i, issue_accept_i, issue_ready_o;
  logic [ID_WIDTH-1:0]   issue_id_i;
  logic                  commit_valid_i, commit_kill_i;
  logic [ID_WIDTH-1:0]   commit_id_i;
  logic                  exec_valid_i, exec_ready_o, exec_we_i;
  logic [ID_WIDTH-1:0]   exec_id_i;
  logic [DATA_WIDTH-1:0] exec_data_i;
  logic [4:0]            exec_rd_i;
  logic                  result_valid_o, result_ready_i, result_we_o;
  logic [ID_WIDTH-1:0]   result_id_o;
  logic [DATA_WIDTH-1:0] result_data_o;
  logic [4:0]            result_rd_o;
  logic [ID_WIDTH:0]     inflight_cnt_o;
  logic                  protocol_err_o;
`ifdef X_COMMIT_TRACKER_KILL_NOTIFY_EN
  logic                  kill_valid_o;
  logic [ID_WIDTH-1:0]   kill_id_o;
`endif

  always #5 clk_i = ~clk_i;

  x_commit_tracker #(
    .ID_WIDTH(ID_WIDTH), .MAX_INFLIGHT(MAX_INFLIGHT), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_id_i(issue_id_i), .issue_accept_i(issue_accept_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .exec_valid_i(exec_valid_i), .exec_ready_o(exec_ready_o), .exec_id_i(exec_id_i),
    .exec_data_i(exec_data_i), .exec_we_i(exec_we_i), .exec_rd_i(exec_rd_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_we_o(result_we_o), .result_rd_o(result_rd_o),
    .inflight_cnt_o(inflight_cnt_o), .protocol_err_o(protocol_err_o)
`ifdef X_COMMIT_TRACKER_KILL_NOTIFY_EN
    ,
    .kill_valid_o(kill_valid_o), .kill_id_o(kill_id_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: which IDs are tracked, and whether each has been committed or killed.
  bit                  m_trk [NUM_IDS], m_cmt [NUM_IDS], m_kil [NUM_IDS];
  bit                  n_trk [NUM_IDS], n_cmt [NUM_IDS], n_kil [NUM_IDS];
  bit                  m_ov, n_ov, m_err, n_err, m_kv, n_kv;
  logic [ID_WIDTH-1:0] m_oid, n_oid, m_kid, n_kid;
  logic [DATA_WIDTH-1:0] m_odata, n_odata;
  bit                  m_owe, n_owe;
  logic [4:0]          m_ord, n_ord;
  bit                  exp_iready, exp_eready;

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < NUM_IDS; i++) c += int'(m_trk[i]);
    return c;
  endfunction

  function automatic bit model_exec_ready(input logic [ID_WIDTH-1:0] id);
    if (!m_trk[id])  return 1'b1;
    if (m_kil[id])   return 1'b1;
    if (m_cmt[id])   return !m_ov || result_ready_i;
    return 1'b0;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      exp_iready = !m_trk[issue_id_i] && (model_cnt() < MAX_INFLIGHT);
      exp_eready = model_exec_ready(exec_id_i);
      chk("cyc_issue_ready", issue_ready_o, exp_iready);
      chk("cyc_exec_ready", exec_ready_o, exp_eready);
      chk("cyc_result_valid", result_valid_o, m_ov);
      if (m_ov) begin
        chk("cyc_result_id", result_id_o, m_oid);
        chk("cyc_result_data", result_data_o, m_odata);
        chk("cyc_result_we", result_we_o, m_owe);
        chk("cyc_result_rd", result_rd_o, m_ord);
      end
      chk("cyc_inflight_cnt", inflight_cnt_o, model_cnt());
      chk("cyc_protocol_err", protocol_err_o, m_err);
`ifdef X_COMMIT_TRACKER_KILL_NOTIFY_EN
      chk("cyc_kill_valid", kill_valid_o, m_kv);
      if (m_kv) chk("cyc_kill_id", kill_id_o, m_kid);
`endif
      n_trk = m_trk; n_cmt = m_cmt; n_kil = m_kil;
      n_ov = m_ov; n_oid = m_oid; n_odata = m_odata; n_owe = m_owe; n_ord = m_ord;
      n_err = m_err; n_kv = 1'b0; n_kid = m_kid;
      if (issue_valid_i && exp_iready && issue_accept_i) begin
        n_trk[issue_id_i] = 1'b1; n_cmt[issue_id_i] = 1'b0; n_kil[issue_id_i] = 1'b0;
      end
      if (commit_valid_i) begin
        if (m_trk[commit_id_i] && !m_cmt[commit_id_i] && !m_kil[commit_id_i]) begin
          if (commit_kill_i) begin
            n_kil[commit_id_i] = 1'b1; n_kv = 1'b1; n_kid = commit_id_i;
          end else begin
            n_cmt[commit_id_i] = 1'b1;
          end
        end else begin
          n_err = 1'b1;
        end
      end
      if (result_ready_i) n_ov = 1'b0;
      if (exec_valid_i && exp_eready) begin
        if (!m_trk[exec_id_i]) begin
          n_err = 1'b1;
        end else begin
          if (m_cmt[exec_id_i]) begin
            n_ov = 1'b1; n_oid = exec_id_i; n_odata = exec_data_i;
            n_owe = exec_we_i; n_ord = exec_rd_i;
          end
          n_trk[exec_id_i] = 1'b0; n_cmt[exec_id_i] = 1'b0; n_kil[exec_id_i] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        m_trk[i] = 1'b0; m_cmt[i] = 1'b0; m_kil[i] = 1'b0;
      end
      m_ov = 1'b0; m_oid = '0; m_odata = '0; m_owe = 1'b0; m_ord = '0;
      m_err = 1'b0; m_kv = 1'b0; m_kid = '0;
    end else begin
      m_trk = n_trk; m_cmt = n_cmt; m_kil = n_kil;
      m_ov = n_ov; m_oid = n_oid; m_odata = n_odata; m_owe = n_owe; m_ord = n_ord;
      m_err = n_err; m_kv = n_kv; m_kid = n_kid;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [ID_WIDTH-1:0] id);
    issue_valid_i = 1'b1; issue_id_i = id; issue_accept_i = 1'b1;
    step();
    issue_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [ID_WIDTH-1:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    step();
    commit_valid_i = 1'b0;
  endtask

  task automatic exec_drive(input logic [ID_WIDTH-1:0] id, input logic [DATA_WIDTH-1:0] data,
                            input logic [4:0] rd);
    exec_valid_i = 1'b1; exec_id_i = id; exec_data_i = data; exec_we_i = 1'b1; exec_rd_i = rd;
  endtask

  initial begin
    rst_i = 1'b1;
    issue_valid_i = 1'b0; issue_id_i = '0; issue_accept_i = 1'b0;
    commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
    exec_valid_i = 1'b0; exec_id_i = '0; exec_data_i = '0; exec_we_i = 1'b0; exec_rd_i = '0;
    result_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_result_valid", result_valid_o, 0);
    chk("rst_inflight_cnt", inflight_cnt_o, 0);
    chk("rst_protocol_err", protocol_err_o, 0);
    rst_i = 1'b0;

    // Issue, commit, complete id 3.
    issue(4'd3);
    chk("t1_cnt_after_issue", inflight_cnt_o, 1);
    commit(4'd3, 1'b0);
    exec_drive(4'd3, 32'hDEADBEEF, 5'd7);
    settle();
    chk("t1_exec_ready", exec_ready_o, 1);
    step();
    exec_valid_i = 1'b0;
    chk("t1_result_valid", result_valid_o, 1);
    chk("t1_result_id", result_id_o, 3);
    chk("t1_result_data", result_data_o, 32'hDEADBEEF);
    chk("t1_cnt_after_exec", inflight_cnt_o, 0);
    step();
    chk("t1_result_drained", result_valid_o, 0);

    // Completion before commit stalls; commit and completion together also stall.
    issue(4'd5);
    exec_drive(4'd5, 32'h0000_0505, 5'd5);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t2_exec_stall", exec_ready_o, 0);
      step();
    end
    commit_valid_i = 1'b1; commit_id_i = 4'd5; commit_kill_i = 1'b0;
    settle();
    chk("t2_same_cycle_stall", exec_ready_o, 0);
    step();
    commit_valid_i = 1'b0;
    settle();
    chk("t2_exec_ready_after_commit", exec_ready_o, 1);
    step();
    exec_valid_i = 1'b0;
    chk("t2_result_valid", result_valid_o, 1);
    chk("t2_result_id", result_id_o, 5);
    step();

    // Fill to MAX_INFLIGHT, free one, re-issue checks.
    for (int k = 0; k < 4; k++) issue(ID_WIDTH'(k));
    issue_valid_i = 1'b1; issue_id_i = 4'd4; issue_accept_i = 1'b1;
    settle();
    chk("t3_full_not_ready", issue_ready_o, 0);
    chk("t3_cnt_full", inflight_cnt_o, 4);
    issue_valid_i = 1'b0;
    commit(4'd0, 1'b0);
    exec_drive(4'd0, 32'h0000_00A0, 5'd1);
    issue_valid_i = 1'b1; issue_id_i = 4'd4;
    settle();
    chk("t3_not_ready_while_freeing", issue_ready_o, 0);
    step();
    exec_valid_i = 1'b0;
    settle();
    chk("t3_id4_ready", issue_ready_o, 1);
    chk("t3_cnt_after_free", inflight_cnt_o, 3);
    issue_id_i = 4'd2;
    settle();
    chk("t3_reissue_busy", issue_ready_o, 0);
    issue_valid_i = 1'b0;
    issue(4'd4);
    chk("t3_cnt_refill", inflight_cnt_o, 4);
    for (int k = 1; k <= 4; k++) commit(ID_WIDTH'(k), 1'b1);
    for (int k = 1; k <= 4; k++) begin
      exec_drive(ID_WIDTH'(k), 32'hFFFF_0000, 5'd2);
      step();
    end
    exec_valid_i = 1'b0;
    chk("t3_cnt_drained", inflight_cnt_o, 0);

    // Killed id 7: completion consumed, no result.
    issue(4'd7);
    commit(4'd7, 1'b1);
`ifdef X_COMMIT_TRACKER_KILL_NOTIFY_EN
    chk("t4_kill_valid", kill_valid_o, 1);
    chk("t4_kill_id", kill_id_o, 7);
`endif
    exec_drive(4'd7, 32'h7777_7777, 5'd7);
    settle();
    chk("t4_exec_ready_killed", exec_ready_o, 1);
    step();
    exec_valid_i = 1'b0;
`ifdef X_COMMIT_TRACKER_KILL_NOTIFY_EN
    chk("t4_kill_pulse_ends", kill_valid_o, 0);
`endif
    chk("t4_no_result", result_valid_o, 0);
    chk("t4_cnt", inflight_cnt_o, 0);

    // Back-pressure: id 1 held, id 2 waits, then both drain in order.
    issue(4'd1); issue(4'd2);
    commit(4'd1, 1'b0); commit(4'd2, 1'b0);
    result_ready_i = 1'b0;
    exec_drive(4'd1, 32'h1111_1111, 5'd11);
    step();
    exec_drive(4'd2, 32'h2222_2222, 5'd12);
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("t5_exec_blocked", exec_ready_o, 0);
      chk("t5_hold_id1", result_id_o, 1);
      step();
    end
    result_ready_i = 1'b1;
    settle();
    chk("t5_exec_ready_on_drain", exec_ready_o, 1);
    step();
    exec_valid_i = 1'b0;
    chk("t5_second_valid", result_valid_o, 1);
    chk("t5_second_id", result_id_o, 2);
    chk("t5_second_data", result_data_o, 32'h2222_2222);
    step();
    chk("t5_drained", result_valid_o, 0);

    // Freeing id 6 and issuing id 6 in the same cycle gives a bubble.
    issue(4'd6);
    commit(4'd6, 1'b0);
    exec_drive(4'd6, 32'h6666_6666, 5'd6);
    issue_valid_i = 1'b1; issue_id_i = 4'd6; issue_accept_i = 1'b0;
    settle();
    chk("t6_bubble", issue_ready_o, 0);
    step();
    exec_valid_i = 1'b0;
    settle();
    chk("t6_ready_after_bubble", issue_ready_o, 1);
    issue_valid_i = 1'b0;
    step();

    // Protocol error on never-issued commit, then asynchronous reset mid-flight.
    commit(4'd9, 1'b0);
    chk("t7_protocol_err", protocol_err_o, 1);
    repeat (3) step();
    chk("t7_protocol_err_sticky", protocol_err_o, 1);
    issue(4'd10); issue(4'd11); issue(4'd12);
    chk("t7_cnt3", inflight_cnt_o, 3);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t7_rst_result_valid", result_valid_o, 0);
    chk("t7_rst_result_data", result_data_o, 0);
    chk("t7_rst_result_id", result_id_o, 0);
    chk("t7_rst_cnt", inflight_cnt_o, 0);
    chk("t7_rst_err", protocol_err_o, 0);
    step();
    rst_i = 1'b0;
    issue_valid_i = 1'b1; issue_id_i = 4'd9; issue_accept_i = 1'b1;
    settle();
    chk("t7_issue9_ready", issue_ready_o, 1);
    step();
    issue_valid_i = 1'b0;
    chk("t7_cnt_after_issue9", inflight_cnt_o, 1);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
